// File: rtl/command_receive_pkg.sv
// Shared constants and types for the MCU command receiver.
package command_receive_pkg;

    localparam logic [7:0] CMD_ERASE       = 8'hA0;
    localparam logic [7:0] CMD_BAUD        = 8'hA1;
    localparam logic [7:0] CMD_DEMAND_ADDR = 8'hA2;

    localparam logic [3:0]  DEF_HDR_NIBBLE    = 4'hA;
    localparam int unsigned DEF_CLKS_PER_BIT  = 24;
    localparam int unsigned DEF_FRAME_TIMEOUT = 12000;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/command_receive_if.sv
// Byte, frame and decoded-command outputs of the command receiver.
interface command_receive_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;
    logic        timeout_err;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_sub;
    logic [15:0] cmd_data;
    logic        en_erase_req;
    logic        en_baud_set;
    logic [7:0]  baud_CMD;
    logic        en_demand_write_addr;

    modport master (
        output byte_valid, byte_data, frame_err, timeout_err,
               cmd_valid, cmd_code, cmd_sub, cmd_data,
               en_erase_req, en_baud_set, baud_CMD, en_demand_write_addr
    );

    modport slave (
        input  byte_valid, byte_data, frame_err, timeout_err,
               cmd_valid, cmd_code, cmd_sub, cmd_data,
               en_erase_req, en_baud_set, baud_CMD, en_demand_write_addr
    );
endinterface

// File: rtl/command_receive_uart_rx_byte.sv
// UART byte receiver: 2-FF synchronizer, falling-edge start detect, 8N1 sampling.
module uart_rx_byte
    import command_receive_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic sync1, sync2, line_prev, fall;

    rx_state_t     state, state_nx;
    logic [CW-1:0] clk_cnt, clk_cnt_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift, shift_nx;
    logic [7:0]    data_nx;
    logic          valid_nx, ferr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= rxd;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    // A start needs a high-to-low transition, so a line stuck low never retriggers.
    assign fall = line_prev & ~sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            clk_cnt    <= clk_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            shift      <= shift_nx;
            byte_data  <= data_nx;
            byte_valid <= valid_nx;
            frame_err  <= ferr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clk_cnt_nx = clk_cnt + 1'b1;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        data_nx    = byte_data;
        valid_nx   = 1'b0;
        ferr_nx    = 1'b0;
        case (state)
            RX_IDLE: begin
                clk_cnt_nx = '0;
                if (fall) begin
                    state_nx   = RX_START;
                    bit_cnt_nx = '0;
                end
            end
            RX_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nx = '0;
                    state_nx   = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_nx = '0;
                    shift_nx   = {sync2, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nx = RX_STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_nx = '0;
                    state_nx   = RX_IDLE;
                    if (sync2) begin
                        valid_nx = 1'b1;
                        data_nx  = shift;
                    end else begin
                        ferr_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/command_receive.sv
// MCU command receiver: assembles 4-byte frames from the UART byte stream,
// aborts stale partial frames, and decodes controller request pulses.
module command_receive
    import command_receive_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int unsigned FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
    parameter logic [3:0]  HDR_NIBBLE    = DEF_HDR_NIBBLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              TXD_MCU,
    command_receive_if.master cmd_if
);

    localparam int unsigned TW = $clog2(FRAME_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(FRAME_TIMEOUT - 1);

    logic          rx_valid, rx_ferr;
    logic [7:0]    rx_data;
    logic [1:0]    idx;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    code_r, sub_r, lo_r;
    logic          cmd_valid, timeout_err;
    logic          en_erase, en_baud, en_dem;
    logic [7:0]    cmd_code, cmd_sub, baud_cmd;
    logic [15:0]   cmd_data;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (TXD_MCU),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .frame_err (rx_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            tmo_cnt     <= '0;
            code_r      <= '0;
            sub_r       <= '0;
            lo_r        <= '0;
            cmd_valid   <= 1'b0;
            timeout_err <= 1'b0;
            en_erase    <= 1'b0;
            en_baud     <= 1'b0;
            en_dem      <= 1'b0;
            cmd_code    <= '0;
            cmd_sub     <= '0;
            cmd_data    <= '0;
            baud_cmd    <= '0;
        end else begin
            cmd_valid   <= 1'b0;
            timeout_err <= 1'b0;
            en_erase    <= 1'b0;
            en_baud     <= 1'b0;
            en_dem      <= 1'b0;
            // A byte landing on the terminal count wins over the timeout.
            if (rx_valid) begin
                tmo_cnt <= '0;
                case (idx)
                    2'd0: begin
                        if (rx_data[7:4] == HDR_NIBBLE) begin
                            code_r <= rx_data;
                            idx    <= 2'd1;
                        end
                    end
                    2'd1: begin
                        sub_r <= rx_data;
                        idx   <= 2'd2;
                    end
                    2'd2: begin
                        lo_r <= rx_data;
                        idx  <= 2'd3;
                    end
                    default: begin
                        idx       <= 2'd0;
                        cmd_valid <= 1'b1;
                        cmd_code  <= code_r;
                        cmd_sub   <= sub_r;
                        cmd_data  <= {rx_data, lo_r};
                        en_erase  <= (code_r == CMD_ERASE);
                        en_baud   <= (code_r == CMD_BAUD);
                        en_dem    <= (code_r == CMD_DEMAND_ADDR);
                        if (code_r == CMD_BAUD) begin
                            baud_cmd <= lo_r;
                        end
                    end
                endcase
            end else if (idx != 2'd0) begin
                if (tmo_cnt == TO_LAST) begin
                    idx         <= 2'd0;
                    timeout_err <= 1'b1;
                    tmo_cnt     <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign cmd_if.byte_valid           = rx_valid;
    assign cmd_if.byte_data            = rx_data;
    assign cmd_if.frame_err            = rx_ferr;
    assign cmd_if.timeout_err          = timeout_err;
    assign cmd_if.cmd_valid            = cmd_valid;
    assign cmd_if.cmd_code             = cmd_code;
    assign cmd_if.cmd_sub              = cmd_sub;
    assign cmd_if.cmd_data             = cmd_data;
    assign cmd_if.en_erase_req         = en_erase;
    assign cmd_if.en_baud_set          = en_baud;
    assign cmd_if.baud_CMD             = baud_cmd;
    assign cmd_if.en_demand_write_addr = en_dem;

endmodule

// File: tb/tb_command_receive.sv
// Scoreboard bench for command_receive: serial stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_command_receive;
    import command_receive_pkg::*;

    localparam int unsigned CPB = 24;
    localparam int unsigned FT  = 12000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic txd   = 1'b1;

    always #5 clk = ~clk;

    command_receive_if bus();

    command_receive #(
        .CLKS_PER_BIT (CPB),
        .FRAME_TIMEOUT(FT),
        .HDR_NIBBLE   (4'hA)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .TXD_MCU(txd),
        .cmd_if (bus)
    );

    typedef struct packed {
        logic [7:0]  code;
        logic [7:0]  sub;
        logic [15:0] data;
        logic        erase;
        logic        baud;
        logic        dem;
        logic [7:0]  baud_cmd;
    } cmd_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bv_cyc = -1;
    int last_start = 0;
    int exp_ferr = 0;
    int exp_tmo = 0;
    logic [7:0] exp_baud = 8'h00;
    logic [7:0] exp_bytes[$];
    cmd_t exp_cmds[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got a pulse, required none", name);
    endtask

    // Monitor: every DUT pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_valid) begin
                bv_cyc = cyc;
                if (exp_bytes.size() == 0) unexpected("byte_valid");
                else check("byte_data", 64'(bus.byte_data), 64'(exp_bytes.pop_front()));
            end
            if (bus.frame_err) begin
                if (exp_ferr == 0) unexpected("frame_err");
                else begin checks++; exp_ferr--; end
            end
            if (bus.timeout_err) begin
                if (exp_tmo == 0) unexpected("timeout_err");
                else begin checks++; exp_tmo--; end
            end
            if (bus.cmd_valid) begin
                cmd_t act;
                act = '{code: bus.cmd_code, sub: bus.cmd_sub, data: bus.cmd_data,
                        erase: bus.en_erase_req, baud: bus.en_baud_set,
                        dem: bus.en_demand_write_addr, baud_cmd: bus.baud_CMD};
                if (exp_cmds.size() == 0) unexpected("cmd_valid");
                else check("cmd", 64'(act), 64'(exp_cmds.pop_front()));
            end else if (bus.en_erase_req || bus.en_baud_set || bus.en_demand_write_addr) begin
                unexpected("en_without_cmd_valid");
            end
        end
    end

    function automatic logic [54:0] all_outputs();
        return {bus.byte_valid, bus.byte_data, bus.frame_err, bus.timeout_err,
                bus.cmd_valid, bus.cmd_code, bus.cmd_sub, bus.cmd_data,
                bus.en_erase_req, bus.en_baud_set, bus.baud_CMD, bus.en_demand_write_addr};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_bytes.push_back(b);
        else exp_ferr++;
        @(negedge clk);
        txd = 1'b0;
        last_start = cyc;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            txd = b[i];
            idle(CPB);
        end
        txd = stop_bit;
        idle(CPB);
        txd = 1'b1;
    endtask

    task automatic push_cmd(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        if (b0 == 8'hA1) exp_baud = b2;
        exp_cmds.push_back('{code: b0, sub: b1, data: {b3, b2},
                             erase: (b0 == 8'hA0), baud: (b0 == 8'hA1),
                             dem: (b0 == 8'hA2), baud_cmd: exp_baud});
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int gap);
        push_cmd(b0, b1, b2, b3);
        send_byte(b0, 1'b1); idle(gap);
        send_byte(b1, 1'b1); idle(gap);
        send_byte(b2, 1'b1); idle(gap);
        send_byte(b3, 1'b1); idle(gap);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_bv, lat, target;

        idle(4);
        check("reset_outputs", 64'(all_outputs()), 64'd0);
        rst_n = 1'b1;
        idle(20);

        // Baud command with 200 us inter-byte gaps.
        send_frame(8'hA1, 8'h00, 8'h05, 8'h00, 4800);

        // Short low glitch, then an erase.
        @(negedge clk); txd = 1'b0;
        idle(5);        txd = 1'b1;
        idle(60);
        send_frame(8'hA0, 8'h00, 8'h00, 8'h00, 48);

        // Bad stop bit mid-frame leaves the frame index alone.
        push_cmd(8'hA2, 8'h00, 8'h34, 8'h12);
        send_byte(8'hA2, 1'b1); idle(48);
        send_byte(8'h00, 1'b1); idle(48);
        send_byte(8'h3C, 1'b0); idle(48);
        send_byte(8'h34, 1'b1); idle(48);
        send_byte(8'h12, 1'b1); idle(48);

        // Resync on a non-header byte, then a back-to-back frame and a plain code.
        send_byte(8'h55, 1'b1);
        send_frame(8'hA2, 8'h00, 8'h01, 8'h00, 0);
        send_frame(8'hA7, 8'h12, 8'h34, 8'h56, 48);

        // Timeout of a partial frame.
        send_byte(8'hA0, 1'b1); idle(48);
        send_byte(8'h00, 1'b1);
        exp_tmo++;
        idle(FT + 1 + 40);
        check("timeout_fired", 64'(exp_tmo), 64'd0);
        send_frame(8'hA0, 8'h00, 8'h00, 8'h00, 48);

        // Second byte lands exactly on the terminal count: no timeout.
        push_cmd(8'hA0, 8'h00, 8'h00, 8'h00);
        send_byte(8'hA0, 1'b1);
        for (int i = 0; i < 400 && bv_cyc < last_start; i++) @(negedge clk);
        check("first_byte_seen", 64'(bv_cyc >= last_start), 64'd1);
        first_bv = bv_cyc;
        lat = bv_cyc - last_start;
        target = first_bv + int'(FT) - lat;
        while (cyc < target - 1) @(negedge clk);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 400 && bv_cyc == first_bv; i++) @(negedge clk);
        check("terminal_gap", 64'(bv_cyc - first_bv), 64'(FT));
        idle(48);
        send_byte(8'h00, 1'b1); idle(48);
        send_byte(8'h00, 1'b1); idle(48);

        // Reset during data bit 4 of byte 3.
        send_byte(8'hA1, 1'b1); idle(48);
        send_byte(8'h00, 1'b1); idle(48);
        send_byte(8'h07, 1'b1); idle(48);
        @(negedge clk); txd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin txd = 1'b0; idle(CPB); end
        txd = 1'b0;
        idle(CPB / 2);
        rst_n = 1'b0;
        exp_baud = 8'h00;
        idle(3);
        check("mid_reset_outputs", 64'(all_outputs()), 64'd0);
        txd = 1'b1;
        idle(10);
        rst_n = 1'b1;
        idle(48);
        check("post_reset_outputs", 64'(all_outputs()), 64'd0);
        send_frame(8'hA1, 8'h00, 8'h09, 8'h00, 48);
        check("baud_after_reset", 64'(bus.baud_CMD), 64'h09);

        idle(400);
        check("bytes_pending", 64'(exp_bytes.size()), 64'd0);
        check("cmds_pending", 64'(exp_cmds.size()), 64'd0);
        check("frame_err_pending", 64'(exp_ferr), 64'd0);
        check("timeout_pending", 64'(exp_tmo), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/command_receive.md
Name: command_receive

Overview:
- Receives command frames from the MCU over its UART TX line (TXD_MCU) and decodes them for the NAND flash controller.
- Complements the FPGA→MCU command transmitter, using the same 10-bit serial format: start bit 0, 8 data bits LSB first, stop bit 1.
- Assembles each 4-byte frame {code, sub, data_lo, data_hi}, validates it, presents it as a record, and raises one-cycle request pulses for the commands the controller acts on.

Parameters:
- CLKS_PER_BIT, 24, clk cycles per UART bit (24 MHz clk, 1 Mbaud); must be ≥ 8.
- FRAME_TIMEOUT, 12000, clk cycles of inter-byte silence that abort a partial frame (500 us). Must exceed the MCU's 200 us inter-byte gap plus one byte time.
- HDR_NIBBLE, 4'hA, required upper nibble of a frame's code byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- TXD_MCU  in  1  serial line from MCU, asynchronous to clk, idle high
- byte_valid  out  1  one-cycle pulse: a byte was received with a good stop bit
- byte_data  out  8  last received byte, held until the next byte
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- timeout_err  out  1  one-cycle pulse: partial frame aborted
- cmd_valid  out  1  one-cycle pulse: complete frame accepted
- cmd_code  out  8  frame byte 0, held until the next frame
- cmd_sub  out  8  frame byte 1, held
- cmd_data  out  16  {byte3, byte2}, held
- en_erase_req  out  1  pulse, code 8'hA0
- en_baud_set  out  1  pulse, code 8'hA1
- baud_CMD  out  8  byte2 of the last A1 frame, held
- en_demand_write_addr  out  1  pulse, code 8'hA2

Behaviour:
- Reset: every output is 0. The synchronizer flops and the previous-line register reset to 1. The FSM goes to IDLE. The frame index and timeout counter reset to 0. Reset asserted mid-byte or mid-frame discards the partial data; after release the receiver waits for the next falling edge.
- Input: 2-FF synchronizer, then a registered copy used for falling-edge detection.
- Byte FSM:
  - IDLE: a falling edge starts bit_cnt=0 and moves to START.
  - START: waits CLKS_PER_BIT/2 cycles, then samples the line. If 0, go to DATA. If 1 (glitch), return to IDLE with no pulse.
  - DATA: samples every CLKS_PER_BIT cycles, shifting 8 bits in LSB first, then goes to STOP.
  - STOP: samples after CLKS_PER_BIT cycles. If 1, pulse byte_valid and update byte_data. If 0, pulse frame_err and discard the byte. Both cases return to IDLE.
  - A new start is recognised only after the line has returned high.
- Latency: byte_valid rises 1 cycle after the stop-bit sample, i.e. about 9.5×CLKS_PER_BIT+4 cycles after the start edge.
- Frame assembler, on byte_valid:
  - idx 0: accept only if byte[7:4]==HDR_NIBBLE, then idx becomes 1. Otherwise drop the byte silently (resync) and stay at idx 0.
  - idx 1–2: store the byte and increment idx.
  - idx 3: store byte3, set idx to 0, and on the following cycle pulse cmd_valid with cmd_code/cmd_sub/cmd_data updated in that same cycle.
  - Decode pulses (en_*) coincide with cmd_valid. Codes A3–AF produce cmd_valid only. baud_CMD updates only on A1.
- frame_err has no effect on idx. The frame completes only if the remaining bytes arrive before the timeout.
- Timeout:
  - The counter clears on every byte_valid and counts while idx≠0.
  - On reaching FRAME_TIMEOUT: idx becomes 0, timeout_err pulses for 1 cycle, and the counter clears.
  - byte_valid takes priority: if it arrives in the same cycle as the terminal count, the byte is accepted into the frame and no timeout fires.
- Back-to-back frames with zero idle bits between stop and start are received correctly. There is no backpressure: a consumer that misses a pulse loses it.

Decomposition:
- Shared package: CMD_ERASE=8'hA0, CMD_BAUD=8'hA1, CMD_DEMAND_ADDR=8'hA2, HDR_NIBBLE, and the default CLKS_PER_BIT.
- Natural sub-module: uart_rx_byte, containing the synchronizer, byte FSM, byte_valid/byte_data and frame_err.
- The frame assembler, timeout and decode stay in command_receive.

Test Plan:
- Baud command: serialize A1 00 05 00 at 24 clk/bit with 200 us gaps → 4 byte_valid; 1 cmd_valid with en_baud_set=1, baud_CMD=8'h05, cmd_data=16'h0005; no other en_* pulses.
- Glitch: drive TXD_MCU low for 5 clks, then idle → no byte_valid, no frame_err; then A0 00 00 00 → en_erase_req pulse.
- Bad stop bit: send byte 0x3C with stop=0 → frame_err pulse, no byte_valid, idx unchanged; the following good A2 00 34 12 → en_demand_write_addr, cmd_data=16'h1234.
- Resync: 55 A2 00 01 00 → 0x55 dropped, then cmd_valid with cmd_code=A2, cmd_data=16'h0001.
- Timeout: A0 00, wait 12001 clks → timeout_err, no cmd_valid; then A0 00 00 00 → en_erase_req. Separately, land a byte exactly at the terminal count → no timeout_err.
- Reset: assert rst_n=0 in the middle of data bit 4 of byte 3 → all outputs 0; a full A1 00 09 00 after release → baud_CMD=8'h09.
